// File: rtl/i2c_repeater.sv
// rtl/i2c_repeater.sv - N-port open-drain I2C repeater with per-line ownership, release lockout and stuck-low detection
module i2c_repeater #(
  parameter int NUM_PORTS     = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int FILT_LEN      = 3,
  parameter int RELEASE_HOLD  = 8,
  parameter int STUCK_TIMEOUT = 100000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_PORTS-1:0] scl_i,
  output logic [NUM_PORTS-1:0] scl_oe,
  input  logic [NUM_PORTS-1:0] sda_i,
  output logic [NUM_PORTS-1:0] sda_oe,
  output logic [NUM_PORTS-1:0] scl_owner,
  output logic [NUM_PORTS-1:0] sda_owner,
  output logic [1:0]           stuck_err,
  input  logic                 err_clr
);

  localparam int                   IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [3:0]           FILT_LAST = 4'(FILT_LEN - 1);
  localparam logic [7:0]           HOLD_INIT = 8'(RELEASE_HOLD);
  localparam logic [23:0]          STUCK_LIM = 24'(STUCK_TIMEOUT);
  localparam logic [NUM_PORTS-1:0] PORT0_OH  = {{(NUM_PORTS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {ST_IDLE, ST_OWNED, ST_RELEASE} line_state_t;

  // Line 0 is SCL, line 1 is SDA; both run the same engine.
  logic [1:0][NUM_PORTS-1:0] w_pin;
  logic [1:0][NUM_PORTS-1:0] w_oe;
  logic [1:0][NUM_PORTS-1:0] w_own;
  logic [1:0]                w_err;

  assign w_pin[0]  = scl_i;
  assign w_pin[1]  = sda_i;
  assign scl_oe    = w_oe[0];
  assign sda_oe    = w_oe[1];
  assign scl_owner = w_own[0];
  assign sda_owner = w_own[1];
  assign stuck_err = w_err;

  for (genvar l = 0; l < 2; l++) begin : g_line
    logic [NUM_PORTS-1:0] r_sync [SYNC_STAGES];
    logic [NUM_PORTS-1:0] r_filt;
    logic [3:0]           r_run [NUM_PORTS];
    line_state_t          r_state;
    logic [IDX_W-1:0]     r_owner;
    logic [NUM_PORTS-1:0] r_oe;
    logic [NUM_PORTS-1:0] r_own_oh;
    logic [7:0]           r_hold;
    logic [23:0]          r_stuck_cnt;
    logic                 r_err;
    logic [IDX_W-1:0]     w_low_idx;
    logic                 w_any_low;
    logic [NUM_PORTS-1:0] w_low_oh;
    logic                 w_owner_high;
    logic                 w_stuck_set;

    // Pin synchronizer; idles high so reset looks like a released bus.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '1;
      end else begin
        r_sync[0] <= w_pin[l];
        for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      end
    end

    // Glitch filter: accept a new level only after FILT_LEN consecutive disagreeing cycles.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        r_filt <= '1;
        for (int p = 0; p < NUM_PORTS; p++) r_run[p] <= '0;
      end else begin
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (r_sync[SYNC_STAGES-1][p] == r_filt[p]) begin
            r_run[p] <= '0;
          end else if (r_run[p] == FILT_LAST) begin
            r_filt[p] <= r_sync[SYNC_STAGES-1][p];
            r_run[p]  <= '0;
          end else begin
            r_run[p] <= r_run[p] + 4'd1;
          end
        end
      end
    end

    // Lowest-index low segment wins arbitration when several go low together.
    always_comb begin
      w_low_idx = '0;
      for (int p = NUM_PORTS - 1; p >= 0; p--) begin
        if (!r_filt[p]) w_low_idx = IDX_W'(p);
      end
    end

    assign w_any_low    = ~&r_filt;
    assign w_low_oh     = PORT0_OH << w_low_idx;
    assign w_owner_high = r_filt[r_owner];

    // Ownership FSM; non-owner inputs are ignored while owned because they read back our own drive.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        r_state  <= ST_IDLE;
        r_owner  <= '0;
        r_oe     <= '0;
        r_own_oh <= '0;
        r_hold   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_oe     <= '0;
            r_own_oh <= '0;
            if (w_any_low) begin
              r_owner  <= w_low_idx;
              r_oe     <= ~w_low_oh;
              r_own_oh <= w_low_oh;
              r_state  <= ST_OWNED;
            end
          end
          ST_OWNED: begin
            if (w_owner_high) begin
              r_oe     <= '0;
              r_own_oh <= '0;
              r_hold   <= HOLD_INIT;
              r_state  <= ST_RELEASE;
            end
          end
          ST_RELEASE: begin
            r_oe     <= '0;
            r_own_oh <= '0;
            r_hold   <= r_hold - 8'd1;
            if (r_hold <= 8'd1) r_state <= ST_IDLE;
          end
          default: begin
            r_oe     <= '0;
            r_own_oh <= '0;
            r_state  <= ST_IDLE;
          end
        endcase
      end
    end

    // Set keeps firing while saturated so a coincident err_clr loses.
    assign w_stuck_set = (r_state == ST_OWNED) && (r_stuck_cnt >= STUCK_LIM - 24'd1);

    // Stuck-low detector: counts owned cycles, saturates, flags a sticky error without breaking ownership.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        r_stuck_cnt <= '0;
        r_err       <= 1'b0;
      end else begin
        if (r_state != ST_OWNED) begin
          r_stuck_cnt <= '0;
        end else if (r_stuck_cnt != STUCK_LIM) begin
          r_stuck_cnt <= r_stuck_cnt + 24'd1;
        end
        if (w_stuck_set) begin
          r_err <= 1'b1;
        end else if (err_clr) begin
          r_err <= 1'b0;
        end
      end
    end

    assign w_oe[l]  = r_oe;
    assign w_own[l] = r_own_oh;
    assign w_err[l] = r_err;
  end

endmodule

// File: tb/tb_i2c_repeater.sv
// tb/tb_i2c_repeater.sv - table vectors, corner sequences and random bus traffic against a cycle model
module tb_i2c_repeater;

  localparam int NP   = 3;
  localparam int SS   = 2;
  localparam int FL   = 3;
  localparam int RH   = 8;
  localparam int TO   = 20;
  localparam int RISE = 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          err_clr;
  logic [NP-1:0] scl_i, sda_i;
  logic [NP-1:0] scl_oe, sda_oe, scl_owner, sda_owner;
  logic [1:0]    stuck_err;

  i2c_repeater #(
    .NUM_PORTS(NP), .SYNC_STAGES(SS), .FILT_LEN(FL),
    .RELEASE_HOLD(RH), .STUCK_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .scl_i(scl_i), .scl_oe(scl_oe),
    .sda_i(sda_i), .sda_oe(sda_oe),
    .scl_owner(scl_owner), .sda_owner(sda_owner),
    .stuck_err(stuck_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // External devices pulling each segment low, plus a slow-rise tail after our drive ends.
  logic [NP-1:0] ext_scl_low, ext_sda_low;
  int rise_scl[NP];
  int rise_sda[NP];

  // Reference model state: line 0 SCL, line 1 SDA. mode 0 idle, 1 owned, 2 release lockout.
  int m_sync[2][NP][SS];
  int m_filt[2][NP];
  int m_run[2][NP];
  int m_mode[2], m_owner[2], m_hold[2], m_oc[2], m_err[2];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < 2; l++) begin
      for (int p = 0; p < NP; p++) begin
        for (int s = 0; s < SS; s++) m_sync[l][p][s] = 1;
        m_filt[l][p] = 1;
        m_run[l][p]  = 0;
      end
      m_mode[l] = 0; m_owner[l] = 0; m_hold[l] = 0; m_oc[l] = 0; m_err[l] = 0;
    end
  endtask

  task automatic model_step(input logic [NP-1:0] pin_scl, input logic [NP-1:0] pin_sda,
                            input logic rst_n, input logic clr);
    int oldf[NP];
    int synced;
    int was_owned;
    int low_idx;
    logic [NP-1:0] pin;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int l = 0; l < 2; l++) begin
      pin = (l == 0) ? pin_scl : pin_sda;
      for (int p = 0; p < NP; p++) begin
        oldf[p] = m_filt[l][p];
        synced  = m_sync[l][p][SS-1];
        for (int s = SS - 1; s > 0; s--) m_sync[l][p][s] = m_sync[l][p][s-1];
        m_sync[l][p][0] = int'(pin[p]);
        if (synced != m_filt[l][p]) begin
          m_run[l][p]++;
          if (m_run[l][p] >= FL) begin
            m_filt[l][p] = synced;
            m_run[l][p]  = 0;
          end
        end else begin
          m_run[l][p] = 0;
        end
      end
      was_owned = (m_mode[l] == 1);
      low_idx = -1;
      for (int p = NP - 1; p >= 0; p--) if (oldf[p] == 0) low_idx = p;
      case (m_mode[l])
        0: if (low_idx >= 0) begin m_mode[l] = 1; m_owner[l] = low_idx; end
        1: if (oldf[m_owner[l]] == 1) begin m_mode[l] = 2; m_hold[l] = RH; end
        default: begin
          m_hold[l]--;
          if (m_hold[l] == 0) m_mode[l] = 0;
        end
      endcase
      if (was_owned) m_oc[l] = (m_oc[l] < TO) ? m_oc[l] + 1 : TO;
      else m_oc[l] = 0;
      if (was_owned && m_oc[l] == TO) m_err[l] = 1;
      else if (clr) m_err[l] = 0;
    end
  endtask

  function automatic logic [13:0] model_out();
    logic [NP-1:0] own[2];
    logic [NP-1:0] oe[2];
    for (int l = 0; l < 2; l++) begin
      own[l] = (m_mode[l] == 1) ? NP'(1 << m_owner[l]) : '0;
      oe[l]  = (m_mode[l] == 1) ? ~own[l] : '0;
    end
    return {oe[0], oe[1], own[0], own[1], m_err[1] != 0, m_err[0] != 0};
  endfunction

  task automatic drive_pins();
    for (int p = 0; p < NP; p++) begin
      scl_i[p] = !(ext_scl_low[p] || (scl_oe[p] === 1'b1) || rise_scl[p] > 0);
      sda_i[p] = !(ext_sda_low[p] || (sda_oe[p] === 1'b1) || rise_sda[p] > 0);
      rise_scl[p] = (scl_oe[p] === 1'b1) ? RISE : ((rise_scl[p] > 0) ? rise_scl[p] - 1 : 0);
      rise_sda[p] = (sda_oe[p] === 1'b1) ? RISE : ((rise_sda[p] > 0) ? rise_sda[p] - 1 : 0);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      drive_pins();
      @(posedge clk);
      model_step(scl_i, sda_i, reset_n, err_clr);
      #2;
      chk("model", {18'd0, scl_oe, sda_oe, scl_owner, sda_owner, stuck_err}, {18'd0, model_out()});
      cyc++;
    end
  endtask

  typedef struct {
    logic [2:0] scl_low;
    logic [2:0] sda_low;
    int         cycles;
    logic [2:0] scl_oe_x;
    logic [2:0] scl_own_x;
    logic [2:0] sda_oe_x;
    logic [2:0] sda_own_x;
  } vec_t;

  vec_t tbl[25];

  initial begin
    int n;
    tbl[0]  = '{3'b000, 3'b000,  4, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[1]  = '{3'b000, 3'b001,  5, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[2]  = '{3'b000, 3'b001,  1, 3'b000, 3'b000, 3'b110, 3'b001};
    tbl[3]  = '{3'b000, 3'b000,  5, 3'b000, 3'b000, 3'b110, 3'b001};
    tbl[4]  = '{3'b000, 3'b000,  1, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[5]  = '{3'b000, 3'b000, 12, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[6]  = '{3'b000, 3'b010,  2, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[7]  = '{3'b000, 3'b000, 10, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[8]  = '{3'b000, 3'b010,  3, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[9]  = '{3'b000, 3'b000,  3, 3'b000, 3'b000, 3'b101, 3'b010};
    tbl[10] = '{3'b000, 3'b000,  2, 3'b000, 3'b000, 3'b101, 3'b010};
    tbl[11] = '{3'b000, 3'b000,  1, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[12] = '{3'b000, 3'b000, 14, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[13] = '{3'b000, 3'b110,  6, 3'b000, 3'b000, 3'b101, 3'b010};
    tbl[14] = '{3'b000, 3'b000,  5, 3'b000, 3'b000, 3'b101, 3'b010};
    tbl[15] = '{3'b000, 3'b000, 15, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[16] = '{3'b100, 3'b000,  6, 3'b011, 3'b100, 3'b000, 3'b000};
    tbl[17] = '{3'b101, 3'b000,  6, 3'b011, 3'b100, 3'b000, 3'b000};
    tbl[18] = '{3'b100, 3'b000,  2, 3'b011, 3'b100, 3'b000, 3'b000};
    tbl[19] = '{3'b001, 3'b000,  5, 3'b011, 3'b100, 3'b000, 3'b000};
    tbl[20] = '{3'b001, 3'b000,  1, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[21] = '{3'b001, 3'b000,  8, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[22] = '{3'b001, 3'b000,  1, 3'b110, 3'b001, 3'b000, 3'b000};
    tbl[23] = '{3'b000, 3'b000,  6, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[24] = '{3'b000, 3'b000, 14, 3'b000, 3'b000, 3'b000, 3'b000};

    reset_n = 1'b0;
    err_clr = 1'b0;
    ext_scl_low = '0;
    ext_sda_low = '0;
    for (int p = 0; p < NP; p++) begin rise_scl[p] = 0; rise_sda[p] = 0; end
    model_reset();
    step(2);
    chk("reset_state", {18'd0, scl_oe, sda_oe, scl_owner, sda_owner, stuck_err}, 32'd0);
    reset_n = 1'b1;

    // Table-driven sequence: bypass latency, release with lockout, glitch, simultaneous, clock stretch.
    for (int i = 0; i < 25; i++) begin
      ext_scl_low = tbl[i].scl_low;
      ext_sda_low = tbl[i].sda_low;
      step(tbl[i].cycles);
      chk($sformatf("vec%0d", i), {20'd0, scl_oe, scl_owner, sda_oe, sda_owner},
          {20'd0, tbl[i].scl_oe_x, tbl[i].scl_own_x, tbl[i].sda_oe_x, tbl[i].sda_own_x});
    end

    // Reset while port0 owns SDA drops every driven low on the next edge.
    ext_sda_low = 3'b001;
    n = 0;
    while (sda_oe !== 3'b110 && n < 20) begin step(1); n++; end
    chk("reset_mid_owned_reached", {31'd0, sda_oe === 3'b110}, 32'd1);
    reset_n = 1'b0;
    ext_sda_low = 3'b000;
    step(1);
    chk("reset_mid_oe", {29'd0, sda_oe}, 32'd0);
    chk("reset_mid_owner", {29'd0, sda_owner}, 32'd0);
    chk("reset_mid_err", {30'd0, stuck_err}, 32'd0);
    reset_n = 1'b1;
    step(20);

    // Stuck SCL: error at the 20th owned cycle, set beats clear, clear works once released.
    ext_scl_low = 3'b001;
    n = 0;
    while (scl_owner === 3'b000 && n < 20) begin step(1); n++; end
    chk("stuck_owner", {29'd0, scl_owner}, 32'd1);
    n = 0;
    while (stuck_err[0] !== 1'b1 && n < 40) begin step(1); n++; end
    chk("stuck_latency", n, 32'd20);
    step(3);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("stuck_set_wins", {31'd0, stuck_err[0]}, 32'd1);
    chk("stuck_still_owned", {29'd0, scl_owner}, 32'd1);
    ext_scl_low = 3'b000;
    step(30);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("stuck_cleared", {30'd0, stuck_err}, 32'd0);

    // Random bus traffic checked every cycle against the model.
    for (int i = 0; i < 250; i++) begin
      ext_scl_low = 3'($urandom) & 3'($urandom);
      ext_sda_low = 3'($urandom) & 3'($urandom);
      n = $urandom_range(1, 14);
      for (int c = 0; c < n; c++) begin
        err_clr = ($urandom_range(0, 15) == 0);
        reset_n = ($urandom_range(0, 299) != 0);
        step(1);
      end
    end
    reset_n = 1'b1;
    err_clr = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_repeater.md
# i2c_repeater

Parametrised N-port I2C bus repeater with bidirectional SDA and SCL, including SCL clock stretching. It sits between the FPGA pins and the I/O tristate buffers and merges NUM_PORTS open-drain segments into one logical bus. Each line (SDA, SCL) has its own synchronizer, glitch filter, ownership FSM, post-release lockout and stuck-low detector. This prevents the latch-up that occurs when the repeater reads back its own driven low.

## Interface
- NUM_PORTS, 2, number of bus segments; legal 2..8
- SYNC_STAGES, 2, input synchronizer flops per pin; legal 2..4
- FILT_LEN, 3, consecutive stable cycles required to accept a level change; legal 1..15
- RELEASE_HOLD, 8, cycles all drivers stay off and inputs are ignored after owner release; legal 1..255
- STUCK_TIMEOUT, 100000, owner-low cycles before stuck error; 24-bit counter

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- scl_i  in  NUM_PORTS  SCL pin levels (from IOBUF outputs)
- scl_oe  out  NUM_PORTS  1 = drive SCL pin low, 0 = Hi-Z
- sda_i  in  NUM_PORTS  SDA pin levels
- sda_oe  out  NUM_PORTS  1 = drive SDA pin low, 0 = Hi-Z
- scl_owner  out  NUM_PORTS  one-hot owning segment of SCL; 0 when none
- sda_owner  out  NUM_PORTS  one-hot owning segment of SDA; 0 when none
- stuck_err  out  2  bit0 SCL, bit1 SDA; sticky stuck-low flags
- err_clr  in  1  single-cycle pulse clears stuck_err

## Operation
- SDA and SCL are identical, independent line engines. The rest of this section describes one line.
- Input path per port: SYNC_STAGES flops (reset to 1), then a glitch filter. The filter holds filt (reset 1) and a run counter. When the synced value differs from filt for FILT_LEN consecutive cycles, filt takes the new value. Any agreeing cycle clears the counter.
- FSM states are IDLE, OWNED and RELEASE. Owner index is held in a register.
- IDLE: all oe = 0. If any filt = 0, the lowest-index low port becomes owner. oe is set to 1 on every other port and stays 0 on the owner; the FSM moves to OWNED.
- OWNED: only the owner's filt is monitored. Non-owner inputs are ignored because they read our own low. When owner filt = 1, all oe go to 0 and the FSM moves to RELEASE with the hold counter = RELEASE_HOLD.
- RELEASE: all oe = 0 and all inputs are ignored. The counter decrements and the FSM enters IDLE when it reaches 0. A segment still low at IDLE entry is taken as a new ownership.
- Owner's oe is never 1. At most one owner exists per line. The owner output is one-hot of the owner index in OWNED and 0 otherwise.
- Stuck detector: a counter increments each OWNED cycle and clears outside OWNED.
  - When the counter reaches STUCK_TIMEOUT, the line's stuck_err bit is set. The counter saturates there.
  - Ownership is not broken by a stuck error.
  - err_clr clears both bits. If err_clr and a set event coincide, set wins.

## Timing
- Reset (reset_n = 0 at a rising edge) sets on the next edge: all oe = 0, owners = 0, stuck_err = 0, FSMs IDLE, sync/filt = 1, counters 0. Mid-transfer reset releases all driven lows within one cycle.
- Pin-to-drive latency: a low applied before edge 0 gives oe = 1 on non-owners after SYNC_STAGES + FILT_LEN + 1 edges. With defaults this is 6 cycles.
- Release latency: owner pin high before edge 0 gives oe = 0 after SYNC_STAGES + FILT_LEN + 1 edges. New ownership is possible no earlier than RELEASE_HOLD cycles later.
- Glitch rule: a pulse shorter than FILT_LEN cycles at the synchronizer output produces no oe change.
- Simultaneous lows in the same filter cycle: the lowest index wins. Other lows are masked by our drive.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset mid-ownership: port0 SDA low, wait for sda_oe = 3'b110, pulse reset_n low for 1 cycle -> next edge sda_oe = 0, sda_owner = 0, stuck_err = 0.
- Basic bypass (NUM_PORTS = 3, defaults): drive sda_i[0] low -> sda_oe = 3'b110 after 6 cycles, sda_owner = 3'b001. Release it -> sda_oe = 0 after 6 cycles, no re-ownership during 8 hold cycles with a modelled slow rise.
- Clock stretch: port2 holds scl_i low while port0 SCL also pulses -> scl_owner = 3'b100, scl_oe = 3'b011 until port2 releases, then hold, then port0 re-owns.
- Glitch: 2-cycle low pulse on sda_i[1] -> sda_oe stays 0. A 3-cycle pulse -> sda_oe = 3'b101.
- Simultaneous: sda_i[2] and sda_i[1] go low on the same edge -> sda_owner = 3'b010, sda_oe = 3'b101.
- Stuck: STUCK_TIMEOUT = 20, hold scl_i[0] low 40 cycles -> stuck_err[0] = 1 at OWNED cycle 20. Pulse err_clr while still owned and saturated -> bit stays 1 (set wins). Release the line then pulse err_clr -> stuck_err = 0.
